// File: rtl/spi_flash_sequencer.sv
// Frames one SPI flash transaction (CS, command, address, dummy, data) over a byte-level SPI master.
// Define SPI_SEQ_TIMEOUT_EN to enable the per-byte watchdog that aborts a stuck transaction.
module spi_flash_sequencer #(
  parameter int unsigned LEN_W         = 16,
  parameter int unsigned CS_SETUP_CLKS = 2,
  parameter int unsigned CS_HOLD_CLKS  = 2,
  parameter int unsigned TIMEOUT_CLKS  = 1024
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Start,
  input  logic [7:0]       i_Cmd,
  input  logic [23:0]      i_Addr,
  input  logic [1:0]       i_Addr_Bytes,
  input  logic [3:0]       i_Dummy_Bytes,
  input  logic [LEN_W-1:0] i_Len,
  input  logic             i_Wr,
  input  logic [1:0]       i_Data_Mode,
  input  logic [7:0]       i_Wr_Data,
  input  logic             i_Wr_Valid,
  output logic             o_Wr_Ready,
  output logic [7:0]       o_Rd_Data,
  output logic             o_Rd_Valid,
  input  logic             i_Rd_Ready,
  output logic             o_Busy,
  output logic             o_Done,
  output logic             o_Err,
  output logic             o_CS_n,
  output logic [7:0]       o_M_TX_Byte,
  output logic             o_M_TX_DV,
  output logic             o_M_RX_Pulse,
  output logic [1:0]       o_M_Bus_Mode,
  input  logic             i_M_TX_Ready,
  input  logic [7:0]       i_M_RX_Byte
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_CMD   = 3'd2;
  localparam logic [2:0] S_ADDR  = 3'd3;
  localparam logic [2:0] S_DUMMY = 3'd4;
  localparam logic [2:0] S_DATA  = 3'd5;
  localparam logic [2:0] S_HOLD  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [1:0] P_ISSUE   = 2'd0;
  localparam logic [1:0] P_WAIT_LO = 2'd1;
  localparam logic [1:0] P_WAIT_HI = 2'd2;
  localparam logic [1:0] P_RD_ACK  = 2'd3;

  localparam int unsigned TMR_MAX = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(CS_SETUP_CLKS - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD  = TMR_W'(CS_HOLD_CLKS - 1);

  logic [2:0]       r_State;
  logic [1:0]       r_Step;
  logic [LEN_W-1:0] r_Cnt;
  logic [TMR_W-1:0] r_Tmr;
  logic [7:0]       r_Cmd;
  logic [23:0]      r_Addr;
  logic [1:0]       r_Addr_Bytes;
  logic [3:0]       r_Dummy;
  logic [LEN_W-1:0] r_Len;
  logic             r_Wr;
  logic [1:0]       r_Mode;
  logic [7:0]       r_Rd_Data;
  logic             r_Rd_Valid;
  logic             r_CS_n;

  logic             w_Byte_Phase;
  logic             w_Wr_Data;
  logic             w_Is_Tx;
  logic             w_Issue_Ok;
  logic             w_Waiting;
  logic             w_Abort;
  logic [2:0]       w_Nxt;
  logic [LEN_W-1:0] w_Nxt_Cnt;
  logic [7:0]       w_Tx_Byte;

  // Phase that follows the current one, skipping any phase whose byte count is zero.
  function automatic logic [2:0] f_after(input logic [2:0] cur, input logic [1:0] ab,
                                         input logic [3:0] dum, input logic [LEN_W-1:0] len);
    logic [2:0] nxt;
    nxt = S_HOLD;
    if (cur == S_CMD && ab != 2'd0) begin
      nxt = S_ADDR;
    end else if ((cur == S_CMD || cur == S_ADDR) && dum != 4'd0) begin
      nxt = S_DUMMY;
    end else if (cur != S_DATA && len != '0) begin
      nxt = S_DATA;
    end
    return nxt;
  endfunction

  always_comb begin
    w_Byte_Phase = (r_State == S_CMD) || (r_State == S_ADDR) ||
                   (r_State == S_DUMMY) || (r_State == S_DATA);
    w_Wr_Data    = (r_State == S_DATA) && r_Wr;
    w_Is_Tx      = (r_State == S_CMD) || (r_State == S_ADDR) || w_Wr_Data;
    w_Issue_Ok   = w_Byte_Phase && (r_Step == P_ISSUE) && i_M_TX_Ready &&
                   (!w_Wr_Data || i_Wr_Valid);
    w_Waiting    = w_Byte_Phase && ((r_Step == P_WAIT_LO) || (r_Step == P_WAIT_HI));
    w_Nxt        = f_after(r_State, r_Addr_Bytes, r_Dummy, r_Len);
    if (w_Nxt == S_ADDR) begin
      w_Nxt_Cnt = LEN_W'(r_Addr_Bytes);
    end else if (w_Nxt == S_DUMMY) begin
      w_Nxt_Cnt = LEN_W'(r_Dummy);
    end else begin
      w_Nxt_Cnt = r_Len;
    end
  end

  // Remaining address-byte count selects the byte, so the MSB of the sent range goes first.
  always_comb begin
    w_Tx_Byte = 8'h00;
    case (r_State)
      S_CMD:  w_Tx_Byte = r_Cmd;
      S_ADDR: begin
        case (r_Cnt[1:0])
          2'd3:    w_Tx_Byte = r_Addr[23:16];
          2'd2:    w_Tx_Byte = r_Addr[15:8];
          default: w_Tx_Byte = r_Addr[7:0];
        endcase
      end
      S_DATA:  w_Tx_Byte = i_Wr_Data;
      default: w_Tx_Byte = 8'h00;
    endcase
  end

  assign o_M_TX_DV    = w_Issue_Ok && w_Is_Tx;
  assign o_M_RX_Pulse = w_Issue_Ok && !w_Is_Tx;
  assign o_M_TX_Byte  = o_M_TX_DV ? w_Tx_Byte : 8'h00;
  assign o_M_Bus_Mode = ((r_State == S_ADDR) || (r_State == S_DUMMY) || (r_State == S_DATA)) ?
                        r_Mode : 2'd0;
  assign o_Wr_Ready   = w_Wr_Data && (r_Step == P_ISSUE) && i_M_TX_Ready;
  assign o_Rd_Data    = r_Rd_Data;
  assign o_Rd_Valid   = r_Rd_Valid;
  assign o_CS_n       = r_CS_n;
  assign o_Busy       = (r_State != S_IDLE) && (r_State != S_DONE);
  assign o_Done       = (r_State == S_DONE);

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CLKS + 1);
  logic [WD_W-1:0] r_Wd;
  logic            r_Err;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Wd  <= '0;
      r_Err <= 1'b0;
    end else begin
      r_Wd <= w_Waiting ? r_Wd + 1'b1 : '0;
      if (w_Abort) begin
        r_Err <= 1'b1;
      end else if (r_State == S_IDLE) begin
        r_Err <= 1'b0;
      end
    end
  end

  assign w_Abort = w_Waiting && (r_Wd == WD_W'(TIMEOUT_CLKS - 1));
  assign o_Err   = r_Err && (r_State == S_DONE);
`else
  assign w_Abort = 1'b0;
  assign o_Err   = 1'b0;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State      <= S_IDLE;
      r_Step       <= P_ISSUE;
      r_Cnt        <= '0;
      r_Tmr        <= '0;
      r_Cmd        <= 8'h00;
      r_Addr       <= 24'h0;
      r_Addr_Bytes <= 2'd0;
      r_Dummy      <= 4'd0;
      r_Len        <= '0;
      r_Wr         <= 1'b0;
      r_Mode       <= 2'd0;
      r_Rd_Data    <= 8'h00;
      r_Rd_Valid   <= 1'b0;
      r_CS_n       <= 1'b1;
    end else if (w_Abort) begin
      r_State    <= S_DONE;
      r_Rd_Valid <= 1'b0;
      r_CS_n     <= 1'b1;
    end else begin
      case (r_State)
        S_IDLE: begin
          if (i_Start) begin
            r_Cmd        <= i_Cmd;
            r_Addr       <= i_Addr;
            r_Addr_Bytes <= i_Addr_Bytes;
            r_Dummy      <= i_Dummy_Bytes;
            r_Len        <= i_Len;
            r_Wr         <= i_Wr;
            r_Mode       <= i_Data_Mode;
            r_Tmr        <= SETUP_LOAD;
            r_CS_n       <= 1'b0;
            r_State      <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_Tmr == '0) begin
            r_State <= S_CMD;
            r_Step  <= P_ISSUE;
          end else begin
            r_Tmr <= r_Tmr - 1'b1;
          end
        end
        S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
          unique case (r_Step)
            P_ISSUE:   if (w_Issue_Ok) r_Step <= P_WAIT_LO;
            P_WAIT_LO: if (!i_M_TX_Ready) r_Step <= P_WAIT_HI;
            P_WAIT_HI: begin
              if (i_M_TX_Ready) begin
                if (r_State == S_DATA && !r_Wr) begin
                  r_Rd_Data  <= i_M_RX_Byte;
                  r_Rd_Valid <= 1'b1;
                  r_Cnt      <= r_Cnt - 1'b1;
                  r_Step     <= P_RD_ACK;
                end else if (r_State == S_CMD || r_Cnt <= 1) begin
                  r_State <= w_Nxt;
                  r_Cnt   <= w_Nxt_Cnt;
                  r_Tmr   <= HOLD_LOAD;
                  r_Step  <= P_ISSUE;
                end else begin
                  r_Cnt  <= r_Cnt - 1'b1;
                  r_Step <= P_ISSUE;
                end
              end
            end
            P_RD_ACK: begin
              // Next read byte is only requested once the consumer has taken this one.
              if (i_Rd_Ready) begin
                r_Rd_Valid <= 1'b0;
                r_Step     <= P_ISSUE;
                if (r_Cnt == '0) begin
                  r_State <= w_Nxt;
                  r_Tmr   <= HOLD_LOAD;
                end
              end
            end
          endcase
        end
        S_HOLD: begin
          if (r_Tmr == '0) begin
            r_CS_n  <= 1'b1;
            r_State <= S_DONE;
          end else begin
            r_Tmr <= r_Tmr - 1'b1;
          end
        end
        default: r_State <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_sequencer.sv
// Bench for spi_flash_sequencer: byte-master model, stream source/sink and a transaction-level model.
module tb_spi_flash_sequencer;

  localparam int unsigned LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [7:0]       cmd = 8'h00;
  logic [23:0]      addr = 24'h0;
  logic [1:0]       ab = 2'd0;
  logic [3:0]       dum = 4'd0;
  logic [LEN_W-1:0] len = '0;
  logic             wr = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [7:0]       wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic             busy, done, err, cs_n;
  logic [7:0]       m_tx_byte;
  logic             m_tx_dv, m_rx_pulse;
  logic [1:0]       m_bus_mode;
  logic             m_ready;
  logic [7:0]       m_rx;

  spi_flash_sequencer #(.LEN_W(LEN_W)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(start), .i_Cmd(cmd), .i_Addr(addr),
    .i_Addr_Bytes(ab), .i_Dummy_Bytes(dum), .i_Len(len), .i_Wr(wr), .i_Data_Mode(mode),
    .i_Wr_Data(wr_data), .i_Wr_Valid(wr_valid), .o_Wr_Ready(wr_ready),
    .o_Rd_Data(rd_data), .o_Rd_Valid(rd_valid), .i_Rd_Ready(rd_ready),
    .o_Busy(busy), .o_Done(done), .o_Err(err), .o_CS_n(cs_n),
    .o_M_TX_Byte(m_tx_byte), .o_M_TX_DV(m_tx_dv), .o_M_RX_Pulse(m_rx_pulse),
    .o_M_Bus_Mode(m_bus_mode), .i_M_TX_Ready(m_ready), .i_M_RX_Byte(m_rx)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic is_rx; logic [7:0] b; logic [1:0] mode;} ev_t;
  typedef struct {
    logic [7:0] cmd; logic [23:0] addr; logic [1:0] ab; logic [3:0] dum;
    int len; logic wr; logic [1:0] mode; int exp_tx; int exp_rx;
  } vec_t;

  ev_t        q_obs[$];
  logic [7:0] q_rx_gen[$];
  logic [7:0] q_rd[$];
  logic [7:0] q_wr_src[$];
  int n_tests = 0, n_fail = 0, prot_err = 0, done_cnt = 0, err_cnt = 0;
  int m_busy = 0, m_max_lat = 3;
  int wr_idx = 0, wr_stall_idx = -1, wr_stall_cnt = 0, rd_stall_pend = 0, rd_stall_cnt = 0;
  logic [1:0] held_mode = 2'd0;
  ev_t mon_e;

  // Byte master: ready drops after each pulse for a random time, RX data is random.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b1;
      m_busy  <= 0;
      m_rx    <= 8'h00;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) m_ready <= 1'b1;
    end else if (m_ready && (m_tx_dv || m_rx_pulse)) begin
      automatic logic [7:0] v = 8'($urandom);
      m_ready <= 1'b0;
      m_busy  <= 1 + int'($urandom_range(0, m_max_lat));
      if (m_rx_pulse) begin
        m_rx <= v;
        q_rx_gen.push_back(v);
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (m_tx_dv || m_rx_pulse) begin
        if (m_tx_dv && m_rx_pulse) prot_err++;
        if (!m_ready || cs_n) prot_err++;
        if (m_tx_dv && wr_ready && !wr_valid) prot_err++;
        mon_e.is_rx = m_rx_pulse;
        mon_e.b     = m_rx_pulse ? 8'h00 : m_tx_byte;
        mon_e.mode  = m_bus_mode;
        q_obs.push_back(mon_e);
        held_mode = m_bus_mode;
      end
      if (!m_ready && m_bus_mode != held_mode) prot_err++;
      if (done) begin
        done_cnt++;
        if (busy || !cs_n) prot_err++;
      end
      if (err) err_cnt++;
    end
  end

  // Write source and read sink, both decided just before the edge that samples them.
  initial begin
    wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_idx == wr_stall_idx && wr_stall_cnt > 0) begin
        wr_valid = 1'b0;
        wr_stall_cnt--;
      end else begin
        wr_valid = (wr_idx < q_wr_src.size()) && ($urandom_range(0, 3) != 0);
      end
      wr_data = (wr_idx < q_wr_src.size()) ? q_wr_src[wr_idx] : 8'h00;
      if (wr_valid && wr_ready) wr_idx++;
      if (rd_valid && rd_stall_pend != 0) begin
        rd_stall_cnt  = 50;
        rd_stall_pend = 0;
      end
      if (rd_stall_cnt > 0) begin
        rd_ready = 1'b0;
        rd_stall_cnt--;
      end else begin
        rd_ready = ($urandom_range(0, 2) != 0);
      end
      if (rd_valid && rd_ready) q_rd.push_back(rd_data);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic ev_t mk_ev(input logic is_rx, input logic [7:0] b, input logic [1:0] md);
    ev_t e;
    e.is_rx = is_rx; e.b = b; e.mode = md;
    return e;
  endfunction

  task automatic run_txn(input logic [7:0] c, input logic [23:0] a, input logic [1:0] b,
                         input logic [3:0] d, input int l, input logic w, input logic [1:0] md,
                         input bit extra);
    ev_t exp[$];
    int t, base, pbase, nrx;
    @(negedge clk);
    q_obs.delete(); q_rx_gen.delete(); q_rd.delete(); q_wr_src.delete();
    wr_idx = 0;
    for (int i = 0; i < l; i++) if (w) q_wr_src.push_back(8'($urandom));
    exp.push_back(mk_ev(1'b0, c, 2'd0));
    for (int i = int'(b) - 1; i >= 0; i--) exp.push_back(mk_ev(1'b0, a[8*i +: 8], md));
    for (int i = 0; i < int'(d); i++) exp.push_back(mk_ev(1'b1, 8'h00, md));
    for (int i = 0; i < l; i++) exp.push_back(w ? mk_ev(1'b0, q_wr_src[i], md) : mk_ev(1'b1, 8'h00, md));
    base = done_cnt; pbase = prot_err;
    cmd = c; addr = a; ab = b; dum = d; len = LEN_W'(l); wr = w; mode = md; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cmd = 8'($urandom); addr = 24'($urandom); ab = 2'($urandom); dum = 4'($urandom);
    len = LEN_W'($urandom_range(0, 5)); wr = 1'($urandom); mode = 2'($urandom);
    if (extra) begin
      repeat (6) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    t = 0;
    while (done_cnt == base && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk("txn_timeout", 64'(t < 4000), 64'd1);
    repeat (3) @(negedge clk);
    chk("done_once", 64'(done_cnt - base), 64'd1);
    chk("ev_count", 64'(q_obs.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < q_obs.size(); i++)
      chk($sformatf("event[%0d]", i), 64'(q_obs[i]), 64'(exp[i]));
    if (w) begin
      chk("wr_consumed", 64'(wr_idx), 64'(l));
    end else begin
      nrx = q_rx_gen.size();
      chk("rd_count", 64'(q_rd.size()), 64'(l));
      for (int i = 0; i < l && i < q_rd.size() && nrx - l + i >= 0; i++)
        chk($sformatf("rd[%0d]", i), 64'(q_rd[i]), 64'(q_rx_gen[nrx - l + i]));
    end
    chk("idle_cs_busy", {62'd0, cs_n, busy}, 64'h2);
    chk("protocol", 64'(prot_err - pbase), 64'd0);
  endtask

  vec_t vecs[5];
  int   ntx, nrx, t, n0;
  logic [7:0] held;

  initial begin
    vecs[0] = '{8'h06, 24'h000000, 2'd0, 4'd0, 0, 1'b1, 2'd0, 1, 0};
    vecs[1] = '{8'h03, 24'h123456, 2'd3, 4'd0, 4, 1'b0, 2'd0, 4, 4};
    vecs[2] = '{8'hEB, 24'hABCDEF, 2'd3, 4'd2, 2, 1'b0, 2'd2, 4, 4};
    vecs[3] = '{8'h02, 24'h000100, 2'd3, 4'd0, 3, 1'b1, 2'd0, 7, 0};
    vecs[4] = '{8'h3B, 24'h00BEEF, 2'd2, 4'd1, 1, 1'b0, 2'd1, 3, 2};

    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {cs_n, busy, done, err, m_tx_dv, m_rx_pulse, wr_ready, rd_valid,
                          m_bus_mode, m_tx_byte, rd_data}, {1'b1, 25'd0});
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      run_txn(vecs[k].cmd, vecs[k].addr, vecs[k].ab, vecs[k].dum, vecs[k].len, vecs[k].wr,
              vecs[k].mode, 1'b0);
      ntx = 0; nrx = 0;
      foreach (q_obs[i]) if (q_obs[i].is_rx) nrx++; else ntx++;
      chk($sformatf("vec%0d_tx", k), 64'(ntx), 64'(vecs[k].exp_tx));
      chk($sformatf("vec%0d_rx", k), 64'(nrx), 64'(vecs[k].exp_rx));
    end

    // Write burst with the producer stalled for 20 cycles after the first byte.
    wr_stall_idx = 1; wr_stall_cnt = 20;
    fork
      run_txn(8'h02, 24'h004000, 2'd3, 4'd0, 3, 1'b1, 2'd0, 1'b0);
      begin
        t = 0;
        while (!(wr_idx == 1 && wr_stall_cnt <= 10) && t < 2000) begin @(negedge clk); t++; end
        #2 n0 = q_obs.size();
        chk("wstall_cs_low", 64'(cs_n), 64'd0);
        while (wr_stall_cnt > 0 && t < 2000) begin @(negedge clk); t++; end
        #2 chk("wstall_no_dv", 64'(q_obs.size()), 64'(n0));
        chk("wstall_cs_low2", 64'(cs_n), 64'd0);
      end
    join
    wr_stall_idx = -1;

    // Read with the consumer refusing the first byte for 50 cycles.
    rd_stall_pend = 1;
    fork
      run_txn(8'h03, 24'h000010, 2'd3, 4'd0, 2, 1'b0, 2'd0, 1'b0);
      begin
        t = 0;
        while (!(rd_stall_cnt > 0 && rd_stall_cnt < 45) && t < 2000) begin @(negedge clk); t++; end
        held = rd_data; n0 = q_obs.size();
        while (rd_stall_cnt > 1 && t < 2000) begin @(negedge clk); t++; end
        #2 chk("rstall_valid_held", {63'd0, rd_valid}, 64'd1);
        chk("rstall_data_held", 64'(rd_data), 64'(held));
        chk("rstall_no_rx", 64'(q_obs.size()), 64'(n0));
      end
    join

    // Second i_Start while busy must be ignored.
    run_txn(8'h0B, 24'h777777, 2'd3, 4'd1, 3, 1'b0, 2'd0, 1'b1);

    for (int r = 0; r < 30; r++) begin
      m_max_lat = int'($urandom_range(0, 6));
      run_txn(8'($urandom), 24'($urandom), 2'($urandom), 4'($urandom_range(0, 3)),
              int'($urandom_range(0, 6)), 1'($urandom), 2'($urandom), 1'b0);
    end

    // Reset in the middle of a read data phase releases CS immediately.
    @(negedge clk);
    q_obs.delete(); q_wr_src.delete(); wr_idx = 0;
    cmd = 8'h03; addr = 24'h0; ab = 2'd3; dum = 4'd0; len = LEN_W'(8); wr = 1'b0; mode = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (q_obs.size() < 6 && t < 2000) begin @(negedge clk); t++; end
    chk("mid_reset_reached_data", 64'(t < 2000), 64'd1);
    chk("mid_reset_cs_low", 64'(cs_n), 64'd0);
    #2 rst_n = 1'b0;
    #1 chk("mid_reset_cs_high", {61'd0, cs_n, busy, rd_valid}, 64'h4);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_txn(8'h06, 24'h0, 2'd0, 4'd0, 0, 1'b0, 2'd0, 1'b0);

    chk("err_never", 64'(err_cnt), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
